divider: RTL and testbench

- Fully pipelined unsigned integer divider: N-bit dividend by M-bit divisor, producing an N-bit quotient ("merchant") and an M-bit remainder.
- Uses the restoring algorithm, one quotient bit per pipeline stage.
- Accepts one operation per clock, with fixed latency; used as a streaming arithmetic block wherever a throughput-1 divide is needed.

---
 rtl/divider_pkg.sv | 26 ++
 rtl/divider_stage.sv | 55 +++++
 rtl/divider.sv | 53 +++++
 tb/tb_divider.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared widths, helpers and stage payload layout for the pipelined divider.
// Used by divider_stage and divider.
package divider_pkg;

  localparam int DIV_N_DEF = 5;
  localparam int DIV_M_DEF = 3;

  // Partial remainder needs one bit more than the divisor.
  function automatic int part_w(input int m);
    return m + 1;
  endfunction

  // Flattened payload width: valid + rem + quo + dvd + dvs.
  function automatic int stage_w(input int n, input int m);
    return 1 + m + n + n + m;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [DIV_M_DEF-1:0] rem;
    logic [DIV_N_DEF-1:0] quo;
    logic [DIV_N_DEF-1:0] dvd;
    logic [DIV_M_DEF-1:0] dvs;
  } div_stage_t;

endpackage

// File: rtl/divider_stage.sv
// One restoring-division step plus its pipeline register.
// Ports: clk, rst_n (sync, active-high), pl_in/pl_out payloads.
module divider_stage
  import divider_pkg::*;
#(
  parameter int N   = DIV_N_DEF,
  parameter int M   = DIV_M_DEF,
  parameter int IDX = 0,
  parameter int SW  = stage_w(N, M)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] pl_in,
  output logic [SW-1:0] pl_out
);

  localparam int PW = part_w(M);
  localparam int QB = N - 1 - IDX;

  typedef struct packed {
    logic         valid;
    logic [M-1:0] rem;
    logic [N-1:0] quo;
    logic [N-1:0] dvd;
    logic [M-1:0] dvs;
  } stage_t;

  stage_t       s_in;
  stage_t       s_nxt;
  stage_t       s_q;
  logic [PW-1:0] partial;
  logic [M-1:0]  diff;
  logic          ge;

  assign s_in = pl_in;

  // Low M bits of the subtraction suffice: a kept result always fits,
  // and with a zero divisor this shifts dividend bits into rem.
  always_comb begin
    partial       = {s_in.rem, s_in.dvd[QB]};
    ge            = partial >= {1'b0, s_in.dvs};
    diff          = partial[M-1:0] - s_in.dvs;
    s_nxt         = s_in;
    s_nxt.quo[QB] = ge;
    s_nxt.rem     = ge ? diff : partial[M-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst_n) s_q <= '0;
    else       s_q <= s_nxt;
  end

  assign pl_out = s_q;

endmodule

// File: rtl/divider.sv
// Fully pipelined restoring unsigned divider, one quotient bit per stage.
// Ports: clk, rst_n (sync, active-high), data_rdy, dividend[N], divisor[M],
// rdy, merchant[N], remainder[M]; div_zero when DIVIDER_DIV_ZERO_FLAG_EN.
module divider
  import divider_pkg::*;
#(
  parameter int N = DIV_N_DEF,
  parameter int M = DIV_M_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         data_rdy,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         rdy,
  output logic [N-1:0] merchant,
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
  output logic [M-1:0] remainder,
  output logic         div_zero
`else
  output logic [M-1:0] remainder
`endif
);

  localparam int SW = stage_w(N, M);

  logic [SW-1:0] pl [N+1];

  assign pl[0] = {data_rdy, {M{1'b0}}, {N{1'b0}}, dividend, divisor};

  for (genvar g = 0; g < N; g++) begin : g_stage
    divider_stage #(
      .N   (N),
      .M   (M),
      .IDX (g)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .pl_in  (pl[g]),
      .pl_out (pl[g+1])
    );
  end

  assign rdy       = pl[N][SW-1];
  assign remainder = pl[N][SW-2 -: M];
  assign merchant  = pl[N][SW-2-M -: N];

`ifdef DIVIDER_DIV_ZERO_FLAG_EN
  // Divisor rides the pipe, so the flag is aligned with rdy.
  assign div_zero = pl[N][SW-1] && (pl[N][M-1:0] == '0);
`endif

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: vector table, sequences, random ops.
// Reference: plain / and % on a delay-line queue of expected results.
module tb_divider;

  localparam int N = 5;
  localparam int M = 3;
  localparam int LAT = N - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         data_rdy;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         rdy;
  logic [N-1:0] merchant;
  logic [M-1:0] remainder;
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
  logic         div_zero;
`endif

  divider #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_rdy  (data_rdy),
    .dividend  (dividend),
    .divisor   (divisor),
    .rdy       (rdy),
    .merchant  (merchant),
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
    .remainder (remainder),
    .div_zero  (div_zero)
`else
    .remainder (remainder)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int a;
    int b;
    int q;
    int r;
  } rec_t;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
  } vec_t;

  rec_t pipe[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pad();
    rec_t e;
    pipe.delete();
    e = '{v: 1'b0, a: 0, b: 0, q: 0, r: 0};
    repeat (LAT) pipe.push_back(e);
  endtask

  task automatic step(input bit v, input int a, input int b,
                      input int eq, input int er);
    rec_t e;
    data_rdy = v;
    dividend = a[N-1:0];
    divisor  = b[M-1:0];
    pipe.push_back('{v: v, a: a, b: b, q: eq, r: er});
    @(posedge clk);
    #1;
    e = pipe.pop_front();
    chk("rdy", int'(rdy), int'(e.v));
    if (e.v) begin
      chk($sformatf("quo %0d/%0d", e.a, e.b), int'(merchant), e.q);
      chk($sformatf("rem %0d/%0d", e.a, e.b), int'(remainder), e.r);
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
      chk("div_zero", int'(div_zero), int'(e.b == 0));
`endif
    end
  endtask

  task automatic op(input bit v, input int a, input int b);
    int q;
    int r;
    if (b == 0) begin
      q = (1 << N) - 1;
      r = a % (1 << M);
    end else begin
      q = a / b;
      r = a % b;
    end
    step(v, a, b, q, r);
  endtask

  task automatic bubble();
    op(1'b0, int'($urandom_range(31)), int'($urandom_range(7)));
  endtask

  task automatic do_reset();
    rst_n    = 1'b1;
    data_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("reset rdy", int'(rdy), 0);
    chk("reset quo", int'(merchant), 0);
    chk("reset rem", int'(remainder), 0);
`ifdef DIVIDER_DIV_ZERO_FLAG_EN
    chk("reset div_zero", int'(div_zero), 0);
`endif
    rst_n = 1'b0;
    pad();
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{a: 25, b: 5, q: 5,  r: 0};
    tbl[1]  = '{a: 16, b: 3, q: 5,  r: 1};
    tbl[2]  = '{a: 10, b: 4, q: 2,  r: 2};
    tbl[3]  = '{a: 15, b: 1, q: 15, r: 0};
    tbl[4]  = '{a: 31, b: 7, q: 4,  r: 3};
    tbl[5]  = '{a: 31, b: 2, q: 15, r: 1};
    tbl[6]  = '{a: 0,  b: 7, q: 0,  r: 0};
    tbl[7]  = '{a: 31, b: 1, q: 31, r: 0};
    tbl[8]  = '{a: 6,  b: 7, q: 0,  r: 6};
    tbl[9]  = '{a: 9,  b: 0, q: 31, r: 1};
    tbl[10] = '{a: 9,  b: 3, q: 3,  r: 0};

    rst_n    = 1'b0;
    data_rdy = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    do_reset();

    // Back-to-back table vectors with literal expectations.
    foreach (tbl[i]) step(1'b1, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r);
    repeat (LAT) bubble();

    // Exhaustive sweep over nonzero divisors.
    for (int b = 1; b < 8; b++)
      for (int a = 0; a < 32; a++) op(1'b1, a, b);
    repeat (LAT) bubble();

    // Alternating bubbles.
    op(1'b1, 20, 6);
    bubble();
    op(1'b1, 7, 3);
    bubble();
    repeat (LAT) bubble();

    // Reset with three operations in flight.
    op(1'b1, 30, 4);
    op(1'b1, 17, 5);
    op(1'b1, 12, 7);
    do_reset();
    op(1'b1, 29, 6);
    repeat (LAT + 2) bubble();

    // Randomized traffic including zero divisors.
    for (int i = 0; i < 300; i++)
      op(bit'($urandom_range(1)), int'($urandom_range(31)),
         int'($urandom_range(7)));
    repeat (LAT) bubble();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
